ahb_default_slave_cfg: RTL and testbench

Parametrised AHB default slave that responds to any transfer not claimed by a real slave in the bus matrix. Adds programmable wait states, a selectable response mode (two-cycle ERROR, or OKAY with a fixed read value), and a sticky first-fault capture with a saturating hit counter. The capture is visible to a debug or status register block. It sits on the matrix default-slave output port, one instance per master port.

---
 rtl/ahb_default_slave_cfg_if.sv | 25 ++
 rtl/ahb_default_slave_cfg.sv | 188 ++++++++++++++++++
 tb/tb_ahb_default_slave_cfg.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_default_slave_cfg_if.sv
// AHB-Lite default-slave bus bundle: the matrix drives the address phase and
// HREADY, the slave returns HREADYOUT, HRESP and HRDATA.
interface ahb_default_slave_cfg_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  HSEL;
    logic [ADDR_WIDTH-1:0] HADDR;
    logic [1:0]            HTRANS;
    logic                  HWRITE;
    logic                  HREADY;
    logic                  HREADYOUT;
    logic [1:0]            HRESP;
    logic [DATA_WIDTH-1:0] HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HREADY,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_default_slave_cfg.sv
// AHB default slave: answers unclaimed transfers after programmable wait states with
// either a two-cycle ERROR or a fixed-data OKAY, and records a sticky first fault.
module ahb_default_slave_cfg #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    WAIT_STATES = 0,
    parameter int                    ERR_MODE    = 1,
    parameter logic [DATA_WIDTH-1:0] RDATA_VAL   = {DATA_WIDTH{1'b0}},
    parameter int                    CNT_WIDTH   = 8
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    ahb_default_slave_cfg_if.slave bus,
    input  logic                  err_clr,
    output logic                  err_valid,
    output logic [ADDR_WIDTH-1:0] err_addr,
    output logic                  err_write,
    output logic [CNT_WIDTH-1:0]  err_count
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_ERR1 = 3'd2,
        ST_ERR2 = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    // Counter reload covers the first wait cycle itself, hence the minus one.
    localparam logic [3:0] WAIT_LOAD   = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam state_t     RESP_STATE  = (ERR_MODE == 1) ? ST_ERR1 : ST_DONE;
    localparam state_t     START_STATE = (WAIT_STATES > 0) ? ST_WAIT : RESP_STATE;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1'b1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    state_t                state_q,     state_d;
    logic [3:0]            wait_cnt_q,  wait_cnt_d;
    logic                  read_q,      read_d;
    logic                  hreadyout_q, hreadyout_d;
    logic [1:0]            hresp_q,     hresp_d;
    logic [DATA_WIDTH-1:0] hrdata_q,    hrdata_d;
    logic                  err_valid_q, err_valid_d;
    logic [ADDR_WIDTH-1:0] err_addr_q,  err_addr_d;
    logic                  err_write_q, err_write_d;
    logic [CNT_WIDTH-1:0]  err_count_q, err_count_d;

    logic accept_s;
    logic unused_htrans0_s;

    // A new address phase is only taken while this slave is signalling ready.
    assign accept_s         = bus.HSEL & bus.HREADY & bus.HTRANS[1] & hreadyout_q;
    assign unused_htrans0_s = bus.HTRANS[0];

    // State register and all registered outputs, async reset to the idle/OKAY state.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= 4'd0;
            read_q      <= 1'b0;
            hreadyout_q <= 1'b1;
            hresp_q     <= RESP_OKAY;
            hrdata_q    <= {DATA_WIDTH{1'b0}};
            err_valid_q <= 1'b0;
            err_addr_q  <= {ADDR_WIDTH{1'b0}};
            err_write_q <= 1'b0;
            err_count_q <= {CNT_WIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            read_q      <= read_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            hrdata_q    <= hrdata_d;
            err_valid_q <= err_valid_d;
            err_addr_q  <= err_addr_d;
            err_write_q <= err_write_d;
            err_count_q <= err_count_d;
        end
    end

    // Next-state logic; ERR2 and DONE may chain straight into a new transfer.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_IDLE, ST_ERR2, ST_DONE: begin
                if (accept_s) begin
                    state_d    = START_STATE;
                    wait_cnt_d = WAIT_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d = RESP_STATE;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            ST_ERR1: begin
                state_d = ST_ERR2;
            end
            default: begin
                state_d    = ST_IDLE;
                wait_cnt_d = 4'd0;
            end
        endcase
    end

    // Bus outputs are decoded from the upcoming state so they leave a flop.
    always_comb begin
        read_d      = accept_s ? ~bus.HWRITE : read_q;
        hreadyout_d = 1'b1;
        hresp_d     = RESP_OKAY;
        hrdata_d    = {DATA_WIDTH{1'b0}};
        case (state_d)
            ST_WAIT: begin
                hreadyout_d = 1'b0;
            end
            ST_ERR1: begin
                hreadyout_d = 1'b0;
                hresp_d     = RESP_ERROR;
            end
            ST_ERR2: begin
                hresp_d = RESP_ERROR;
            end
            ST_DONE: begin
                if (read_d) begin
                    hrdata_d = RDATA_VAL;
                end else begin
                    hrdata_d = {DATA_WIDTH{1'b0}};
                end
            end
            default: begin
                hreadyout_d = 1'b1;
                hresp_d     = RESP_OKAY;
                hrdata_d    = {DATA_WIDTH{1'b0}};
            end
        endcase
    end

    // Fault capture: clear wins first, then a coinciding accept is recorded as a fresh fault.
    always_comb begin
        err_valid_d = err_valid_q;
        err_addr_d  = err_addr_q;
        err_write_d = err_write_q;
        err_count_d = err_count_q;
        if (err_clr) begin
            err_valid_d = 1'b0;
            err_count_d = {CNT_WIDTH{1'b0}};
        end else begin
            err_valid_d = err_valid_q;
        end
        if (accept_s) begin
            err_valid_d = 1'b1;
            if (err_clr || !err_valid_q) begin
                err_addr_d  = bus.HADDR;
                err_write_d = bus.HWRITE;
            end else begin
                err_addr_d  = err_addr_q;
                err_write_d = err_write_q;
            end
            if (err_clr) begin
                err_count_d = CNT_ONE;
            end else if (err_count_q != CNT_MAX) begin
                err_count_d = err_count_q + CNT_ONE;
            end else begin
                err_count_d = err_count_q;
            end
        end else begin
            err_write_d = err_write_d;
        end
    end

    assign bus.HREADYOUT = hreadyout_q;
    assign bus.HRESP     = hresp_q;
    assign bus.HRDATA    = hrdata_q;
    assign err_valid     = err_valid_q;
    assign err_addr      = err_addr_q;
    assign err_write     = err_write_q;
    assign err_count     = err_count_q;

endmodule

// File: tb/tb_ahb_default_slave_cfg.sv
// Bench for ahb_default_slave_cfg: three configurations share one stimulus bus;
// per-cycle expected responses are queued when a transfer is driven.
module tb_ahb_default_slave_cfg;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_BUSY   = 2'b01;
    localparam logic [1:0] T_NONSEQ = 2'b10;

    typedef struct packed {
        logic        rdy;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } exp_t;

    logic HCLK    = 1'b0;
    logic HRESETn = 1'b0;
    always #5 HCLK = ~HCLK;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    exp_t        sb_q[$];
    logic        chk_en = 1'b0;
    int          dut_sel = 0;

    logic        sel_r = 1'b0, rdy_en = 1'b1, clr_r = 1'b0, write_r = 1'b0;
    logic [1:0]  trans_r = T_IDLE;
    logic [31:0] addr_r = 32'h0;

    int          ws_c [3];
    int          em_c [3];
    logic [31:0] rv_c [3];

    logic        m_valid [3];
    logic [31:0] m_addr  [3];
    logic        m_write [3];
    int          m_cnt   [3];
    logic        p_acc, p_clr, p_write;
    logic [31:0] p_addr;
    int          p_dut;

    logic        ev [3];
    logic [31:0] ea [3];
    logic        ew [3];
    logic [7:0]  ec [3];

    ahb_default_slave_cfg_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0();
    ahb_default_slave_cfg_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1();
    ahb_default_slave_cfg_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus2();

    assign bus0.HSEL = sel_r & (dut_sel == 0);
    assign bus1.HSEL = sel_r & (dut_sel == 1);
    assign bus2.HSEL = sel_r & (dut_sel == 2);
    assign bus0.HADDR = addr_r;   assign bus1.HADDR = addr_r;   assign bus2.HADDR = addr_r;
    assign bus0.HTRANS = trans_r; assign bus1.HTRANS = trans_r; assign bus2.HTRANS = trans_r;
    assign bus0.HWRITE = write_r; assign bus1.HWRITE = write_r; assign bus2.HWRITE = write_r;
    assign bus0.HREADY = bus0.HREADYOUT & rdy_en;
    assign bus1.HREADY = bus1.HREADYOUT & rdy_en;
    assign bus2.HREADY = bus2.HREADYOUT & rdy_en;

    ahb_default_slave_cfg #(.WAIT_STATES(0), .ERR_MODE(1)) dut0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus0.slave), .err_clr(clr_r & (dut_sel == 0)),
        .err_valid(ev[0]), .err_addr(ea[0]), .err_write(ew[0]), .err_count(ec[0]));
    ahb_default_slave_cfg #(.WAIT_STATES(3), .ERR_MODE(1)) dut1 (
        .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus1.slave), .err_clr(clr_r & (dut_sel == 1)),
        .err_valid(ev[1]), .err_addr(ea[1]), .err_write(ew[1]), .err_count(ec[1]));
    ahb_default_slave_cfg #(.WAIT_STATES(0), .ERR_MODE(0), .RDATA_VAL(32'hDEAD_BEEF)) dut2 (
        .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus2.slave), .err_clr(clr_r & (dut_sel == 2)),
        .err_valid(ev[2]), .err_addr(ea[2]), .err_write(ew[2]), .err_count(ec[2]));

    logic        o_rdy;
    logic [1:0]  o_resp;
    logic [31:0] o_rdata;

    always_comb begin
        case (dut_sel)
            0:       begin o_rdy = bus0.HREADYOUT; o_resp = bus0.HRESP; o_rdata = bus0.HRDATA; end
            1:       begin o_rdy = bus1.HREADYOUT; o_resp = bus1.HRESP; o_rdata = bus1.HRDATA; end
            default: begin o_rdy = bus2.HREADYOUT; o_resp = bus2.HRESP; o_rdata = bus2.HRDATA; end
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic r, input logic [1:0] s, input logic [31:0] d);
        exp_t e;
        e.rdy = r; e.resp = s; e.rdata = d;
        return e;
    endfunction

    // Scoreboard sink: one queued expectation per clock while checking is enabled.
    always @(negedge HCLK) begin
        exp_t e;
        if (chk_en && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk($sformatf("d%0d.hreadyout@%0t", dut_sel, $time), {63'h0, o_rdy}, {63'h0, e.rdy});
            chk($sformatf("d%0d.hresp@%0t", dut_sel, $time), {62'h0, o_resp}, {62'h0, e.resp});
            chk($sformatf("d%0d.hrdata@%0t", dut_sel, $time), {32'h0, o_rdata}, {32'h0, e.rdata});
        end
    end

    // Capture model, updated at the clock edge that follows the driven cycle.
    task automatic model_apply();
        if (p_clr) begin
            m_valid[p_dut] = 1'b0;
            m_cnt[p_dut]   = 0;
        end
        if (p_acc) begin
            if (!m_valid[p_dut]) begin
                m_addr[p_dut]  = p_addr;
                m_write[p_dut] = p_write;
            end
            m_valid[p_dut] = 1'b1;
            if (m_cnt[p_dut] < 255) m_cnt[p_dut]++;
        end
        p_acc = 1'b0;
        p_clr = 1'b0;
    endtask

    task automatic bus_cycle(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                             input logic wr, input logic clr, input logic rdy);
        bit acc;
        @(posedge HCLK);
        model_apply();
        #1;
        sel_r = sel; trans_r = trans; addr_r = addr; write_r = wr; clr_r = clr; rdy_en = rdy;
        acc = sel && trans[1] && rdy && (sb_q.size() == 1) && sb_q[0].rdy;
        p_dut = dut_sel; p_clr = clr; p_acc = acc; p_addr = addr; p_write = wr;
        if (acc) begin
            for (int i = 0; i < ws_c[dut_sel]; i++) sb_q.push_back(mk(1'b0, 2'b00, 32'h0));
            if (em_c[dut_sel] == 1) begin
                sb_q.push_back(mk(1'b0, 2'b01, 32'h0));
                sb_q.push_back(mk(1'b1, 2'b01, 32'h0));
            end else begin
                sb_q.push_back(mk(1'b1, 2'b00, wr ? 32'h0 : rv_c[dut_sel]));
            end
        end else if (sb_q.size() <= 1) begin
            sb_q.push_back(mk(1'b1, 2'b00, 32'h0));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bus_cycle(1'b0, T_IDLE, 32'h0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic check_err(input string tag);
        chk({tag, ".err_valid"}, {63'h0, ev[dut_sel]}, {63'h0, m_valid[dut_sel]});
        chk({tag, ".err_addr"},  {32'h0, ea[dut_sel]}, {32'h0, m_addr[dut_sel]});
        chk({tag, ".err_write"}, {63'h0, ew[dut_sel]}, {63'h0, m_write[dut_sel]});
        chk({tag, ".err_count"}, {56'h0, ec[dut_sel]}, 64'(m_cnt[dut_sel]));
    endtask

    task automatic assert_rst();
        chk_en  = 1'b0;
        HRESETn = 1'b0;
        sb_q.delete();
        for (int d = 0; d < 3; d++) begin
            m_valid[d] = 1'b0; m_addr[d] = 32'h0; m_write[d] = 1'b0; m_cnt[d] = 0;
        end
        p_acc = 1'b0; p_clr = 1'b0; p_dut = 0; p_addr = 32'h0; p_write = 1'b0;
        sel_r = 1'b0; trans_r = T_IDLE; clr_r = 1'b0; rdy_en = 1'b1;
    endtask

    task automatic release_rst();
        repeat (2) @(posedge HCLK);
        #3;
        HRESETn = 1'b1;
        sb_q.push_back(mk(1'b1, 2'b00, 32'h0));
        sb_q.push_back(mk(1'b1, 2'b00, 32'h0));
        chk_en = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ws_c[0] = 0; ws_c[1] = 3; ws_c[2] = 0;
        em_c[0] = 1; em_c[1] = 1; em_c[2] = 0;
        rv_c[0] = 32'h0; rv_c[1] = 32'h0; rv_c[2] = 32'hDEAD_BEEF;
        assert_rst();
        release_rst();
        idle(1);
        for (int d = 0; d < 3; d++) begin
            dut_sel = d;
            check_err($sformatf("reset.d%0d", d));
        end

        // Single ERROR read with no wait states.
        dut_sel = 0;
        idle(1);
        bus_cycle(1'b1, T_NONSEQ, 32'h4000_0010, 1'b0, 1'b0, 1'b1);
        idle(3);
        check_err("t1");
        chk("t1.addr", {32'h0, ea[0]}, 64'h4000_0010);
        chk("t1.count", {56'h0, ec[0]}, 64'd1);

        // Clear alone: flags drop, first-fault address is kept.
        bus_cycle(1'b0, T_IDLE, 32'h0, 1'b0, 1'b1, 1'b1);
        idle(1);
        check_err("clr");
        chk("clr.addr_hold", {32'h0, ea[0]}, 64'h4000_0010);

        // NONSEQ held through ERR1/ERR2 chains a second error sequence.
        bus_cycle(1'b1, T_NONSEQ, 32'h0000_0100, 1'b0, 1'b0, 1'b1);
        bus_cycle(1'b1, T_NONSEQ, 32'h0000_0104, 1'b0, 1'b0, 1'b1);
        bus_cycle(1'b1, T_NONSEQ, 32'h0000_0104, 1'b0, 1'b0, 1'b1);
        idle(3);
        check_err("t4");
        chk("t4.addr", {32'h0, ea[0]}, 64'h100);
        chk("t4.count", {56'h0, ec[0]}, 64'd2);

        // IDLE, BUSY and HREADY-low cycles are ignored.
        bus_cycle(1'b1, T_IDLE, 32'h300, 1'b0, 1'b0, 1'b1);
        bus_cycle(1'b1, T_BUSY, 32'h300, 1'b0, 1'b0, 1'b1);
        bus_cycle(1'b1, T_NONSEQ, 32'h300, 1'b1, 1'b0, 1'b0);
        idle(2);
        check_err("t6b");

        // Three wait states in ERROR mode.
        dut_sel = 1;
        bus_cycle(1'b1, T_NONSEQ, 32'hA000_0000, 1'b1, 1'b0, 1'b1);
        idle(6);
        check_err("t2");

        // OKAY mode with fixed read data, back to back.
        dut_sel = 2;
        for (int i = 0; i < 4; i++) bus_cycle(1'b1, T_NONSEQ, 32'h10 + 32'(4 * i), 1'b0, 1'b0, 1'b1);
        bus_cycle(1'b1, T_NONSEQ, 32'h20, 1'b1, 1'b0, 1'b1);
        chk("t3.count4", {56'h0, ec[2]}, 64'd4);
        idle(2);
        check_err("t3");

        // Clear coinciding with an accept, then saturation.
        bus_cycle(1'b1, T_NONSEQ, 32'h30, 1'b0, 1'b0, 1'b1);
        bus_cycle(1'b1, T_NONSEQ, 32'h34, 1'b0, 1'b0, 1'b1);
        bus_cycle(1'b1, T_NONSEQ, 32'h200, 1'b1, 1'b1, 1'b1);
        chk("t5.pre", {56'h0, ec[2]}, 64'd7);
        idle(1);
        check_err("t5");
        chk("t5.count", {56'h0, ec[2]}, 64'd1);
        chk("t5.addr", {32'h0, ea[2]}, 64'h200);
        for (int i = 0; i < 300; i++) bus_cycle(1'b1, T_NONSEQ, 32'(4 * i), i[0], 1'b0, 1'b1);
        idle(2);
        check_err("t5.sat");
        chk("t5.sat_count", {56'h0, ec[2]}, 64'd255);

        // Async reset in the middle of a wait sequence.
        dut_sel = 1;
        idle(1);
        bus_cycle(1'b1, T_NONSEQ, 32'hB000_0004, 1'b1, 1'b0, 1'b1);
        idle(1);
        check_err("t6.pre");
        #2;
        assert_rst();
        #1;
        chk("t6.rst_hreadyout", {63'h0, o_rdy}, 64'd1);
        chk("t6.rst_hresp", {62'h0, o_resp}, 64'd0);
        chk("t6.rst_count", {56'h0, ec[1]}, 64'd0);
        chk("t6.rst_valid", {63'h0, ev[1]}, 64'd0);
        release_rst();
        idle(1);
        check_err("t6.post");

        // Recovery after reset.
        dut_sel = 0;
        bus_cycle(1'b1, T_NONSEQ, 32'h500, 1'b0, 1'b0, 1'b1);
        idle(3);
        check_err("recover");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
